ifu_fetch: RTL

//  Instruction-fetch reader at the consumer end of the PC interface: accepts a

---
 rtl/ifu_fetch.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// Instruction-fetch reader: takes one PC from the PC block, performs one
// instruction-memory read (req/gnt, then rvalid), and hands {pc, inst, fault}
// to the decoder. Handles redirect flushes, misaligned PCs, bus errors and
// response timeouts. Only one fetch is outstanding at a time.
module ifu_fetch #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_valid,
    output logic        pc_ready,
    input  logic [31:0] pc_addr,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst,
    output logic [1:0]  inst_fault
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    localparam logic [1:0] F_NONE     = 2'd0;
    localparam logic [1:0] F_MISALIGN = 2'd1;
    localparam logic [1:0] F_BUSERR   = 2'd2;
    localparam logic [1:0] F_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_HOLD  = 3'd4
    } state_e;

    state_e         state_q;
    logic           kill_q;
    logic           drop_q;
    logic [TW-1:0]  timer_q;
    logic [AW-1:0]  addr_q;
    logic           mem_req_q;
    logic [AW-1:0]  mem_addr_q;
    logic           inst_valid_q;
    logic [AW-1:0]  inst_pc_q;
    logic [DW-1:0]  inst_q;
    logic [1:0]     inst_fault_q;

    logic           pc_fire;
    logic           pc_misaligned;
    logic           rsp;
    logic           stray;
    logic           timer_hit;
    logic [TW-1:0]  timer_inc;

    // Handshake qualifiers and response classification
    assign pc_ready      = ~flush & ((state_q == S_IDLE) | ((state_q == S_HOLD) & inst_ready));
    assign pc_fire       = pc_valid & pc_ready;
    assign pc_misaligned = (pc_addr[1:0] != 2'b00);
    assign stray         = mem_rvalid & drop_q;
    assign rsp           = mem_rvalid & ~drop_q;
    assign timer_hit     = (timer_q == TMAX);
    assign timer_inc     = timer_hit ? timer_q : timer_q + TW'(1);

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign inst_valid = inst_valid_q;
    assign inst_pc    = inst_pc_q;
    assign inst       = inst_q;
    assign inst_fault = inst_fault_q;

    // Fetch FSM: state, flags, timer and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            kill_q       <= 1'b0;
            drop_q       <= 1'b0;
            timer_q      <= '0;
            addr_q       <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            inst_valid_q <= 1'b0;
            inst_pc_q    <= '0;
            inst_q       <= '0;
            inst_fault_q <= F_NONE;
        end else begin
            // A response owed to an earlier timed-out fetch is swallowed wherever it lands
            if (stray) begin
                drop_q <= 1'b0;
            end

            case (state_q)
                S_IDLE, S_HOLD: begin
                    if ((state_q == S_HOLD) && (flush || inst_ready)) begin
                        inst_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                    if (pc_fire) begin
                        addr_q <= pc_addr;
                        kill_q <= 1'b0;
                        if (pc_misaligned) begin
                            state_q      <= S_HOLD;
                            inst_valid_q <= 1'b1;
                            inst_pc_q    <= pc_addr;
                            inst_q       <= '0;
                            inst_fault_q <= F_MISALIGN;
                        end else begin
                            state_q    <= S_REQ;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= {pc_addr[AW-1:2], 2'b00};
                        end
                    end
                end

                S_REQ: begin
                    // The request stays up even when flushed; kill marks the answer as unwanted
                    if (flush) begin
                        kill_q <= 1'b1;
                    end
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        timer_q   <= '0;
                        state_q   <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    timer_q <= timer_inc;
                    if (rsp) begin
                        kill_q <= 1'b0;
                        if (kill_q || flush) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q      <= S_HOLD;
                            inst_valid_q <= 1'b1;
                            inst_pc_q    <= addr_q;
                            inst_q       <= mem_err ? '0 : mem_rdata;
                            inst_fault_q <= mem_err ? F_BUSERR : F_NONE;
                        end
                    end else if (flush) begin
                        kill_q  <= 1'b0;
                        state_q <= S_DRAIN;
                    end else if (timer_hit) begin
                        // Response still owed by memory: absorb it when it finally shows up
                        kill_q <= 1'b0;
                        drop_q <= 1'b1;
                        if (kill_q) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q      <= S_HOLD;
                            inst_valid_q <= 1'b1;
                            inst_pc_q    <= addr_q;
                            inst_q       <= '0;
                            inst_fault_q <= F_TIMEOUT;
                        end
                    end
                end

                S_DRAIN: begin
                    timer_q <= timer_inc;
                    if (rsp) begin
                        state_q <= S_IDLE;
                    end else if (timer_hit) begin
                        drop_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
